clock_keeper: RTL and testbench



---
 rtl/clock_keeper_pkg.sv | 24 ++
 rtl/clock_keeper_mod_counter.sv | 30 +++
 rtl/clock_keeper.sv | 196 +++++++++++++++++++
 tb/tb_clock_keeper.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_keeper_pkg.sv
// clock_keeper_pkg: shared types and constants for the clock timekeeping stage.
// Holds the mode-machine state enum, the field-select encodings, the default
// wrap limits, and a small wrapping-increment helper.
package clock_keeper_pkg;

    typedef enum logic [1:0] {
        STATE_RUN   = 2'd0,
        STATE_SET   = 2'd1,
        STATE_ALARM = 2'd2
    } state_t;

    localparam logic [1:0] FIELD_HOUR   = 2'd0;
    localparam logic [1:0] FIELD_MINUTE = 2'd1;
    localparam logic [1:0] FIELD_SECOND = 2'd2;

    localparam int HOUR_LIMIT   = 23;
    localparam int MINSEC_LIMIT = 59;

    // Next value of a field that wraps to zero after reaching its limit.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] limit);
        return (value >= limit) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/clock_keeper_mod_counter.sv
// mod_counter: 6-bit modulo counter used for the running second, minute and
// hour. A load takes priority over an increment. carry is asserted in the
// cycle an increment wraps the counter, so counters can be chained.
module mod_counter
    import clock_keeper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic [5:0] limit,
    output logic [5:0] value,
    output logic       carry
);

    assign carry = inc && !load && (value >= limit);

    // Counter register: load wins over increment; increment wraps at limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 6'd0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= wrap_inc(value, limit);
        end
    end

endmodule

// File: rtl/clock_keeper.sv
// clock_keeper: running hh:mm:ss time, RUN/SET/ALARM edit machine, alarm
// registers and alarm ring with key silencing.
// Optional hourly chime: define CLOCK_KEEPER_HOURLY_CHIME_EN to build it;
// otherwise chime is tied low.
//
// Key inputs are one-cycle pulses; every high cycle is one event. key_mode
// outranks key_next/key_inc. All outputs come straight from registers, so a
// pulse sampled at edge n is visible right after edge n.
module clock_keeper
    import clock_keeper_pkg::*;
#(
    parameter int MAX_HOUR   = HOUR_LIMIT,
    parameter int MAX_MINSEC = MINSEC_LIMIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_next,
    input  logic       key_inc,
    input  logic       alarm_on,
    output logic [5:0] run_hour,
    output logic [5:0] run_minute,
    output logic [5:0] run_second,
    output logic [5:0] edit_hour,
    output logic [5:0] edit_minute,
    output logic [5:0] edit_second,
    output logic       set_en,
    output logic       alarm_en,
    output logic [1:0] field_sel,
    output logic       alarm_ring,
    output logic       chime
);

    localparam logic [5:0] HOUR_LIM   = 6'(MAX_HOUR);
    localparam logic [5:0] MINSEC_LIM = 6'(MAX_MINSEC);

    state_t     state;
    logic [5:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic       commit;
    logic       run_tick;
    logic       sec_carry;
    logic       min_carry;
    logic       hour_carry;
    logic       alarm_match;
    logic       any_key;
    logic       silence;
    logic       silence_nxt;

    // Leaving SET copies the edit fields into the running time; a tick in
    // that same cycle is dropped so the committed value is what appears.
    assign commit   = (state == STATE_SET) && key_mode;
    assign run_tick = tick_1hz && (state != STATE_SET);

    assign set_en   = (state == STATE_SET);
    assign alarm_en = (state == STATE_ALARM);

    mod_counter u_second (
        .clk      (clk),
        .rst      (rst),
        .inc      (run_tick),
        .load     (commit),
        .load_val (edit_second),
        .limit    (MINSEC_LIM),
        .value    (run_second),
        .carry    (sec_carry)
    );

    mod_counter u_minute (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_carry),
        .load     (commit),
        .load_val (edit_minute),
        .limit    (MINSEC_LIM),
        .value    (run_minute),
        .carry    (min_carry)
    );

    mod_counter u_hour (
        .clk      (clk),
        .rst      (rst),
        .inc      (min_carry),
        .load     (commit),
        .load_val (edit_hour),
        .limit    (HOUR_LIM),
        .value    (run_hour),
        .carry    (hour_carry)
    );

    // Mode machine with the edit and alarm registers it owns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= STATE_RUN;
            field_sel    <= FIELD_HOUR;
            edit_hour    <= 6'd0;
            edit_minute  <= 6'd0;
            edit_second  <= 6'd0;
            alarm_hour   <= 6'd0;
            alarm_minute <= 6'd0;
        end else begin
            case (state)
                STATE_RUN: begin
                    if (key_mode) begin
                        state       <= STATE_SET;
                        field_sel   <= FIELD_HOUR;
                        edit_hour   <= run_hour;
                        edit_minute <= run_minute;
                        edit_second <= run_second;
                    end
                end
                STATE_SET: begin
                    if (key_mode) begin
                        state       <= STATE_ALARM;
                        field_sel   <= FIELD_HOUR;
                        edit_hour   <= alarm_hour;
                        edit_minute <= alarm_minute;
                        edit_second <= 6'd0;
                    end else begin
                        if (key_inc) begin
                            case (field_sel)
                                FIELD_HOUR:   edit_hour   <= wrap_inc(edit_hour, HOUR_LIM);
                                FIELD_MINUTE: edit_minute <= wrap_inc(edit_minute, MINSEC_LIM);
                                FIELD_SECOND: edit_second <= wrap_inc(edit_second, MINSEC_LIM);
                                default: ;
                            endcase
                        end
                        if (key_next) begin
                            field_sel <= (field_sel >= FIELD_SECOND) ? FIELD_HOUR : field_sel + 2'd1;
                        end
                    end
                end
                STATE_ALARM: begin
                    if (key_mode) begin
                        state     <= STATE_RUN;
                        field_sel <= FIELD_HOUR;
                    end else begin
                        if (key_inc) begin
                            if (field_sel == FIELD_HOUR) begin
                                alarm_hour <= wrap_inc(alarm_hour, HOUR_LIM);
                                edit_hour  <= wrap_inc(alarm_hour, HOUR_LIM);
                            end else begin
                                alarm_minute <= wrap_inc(alarm_minute, MINSEC_LIM);
                                edit_minute  <= wrap_inc(alarm_minute, MINSEC_LIM);
                            end
                        end
                        if (key_next) begin
                            field_sel <= (field_sel == FIELD_HOUR) ? FIELD_MINUTE : FIELD_HOUR;
                        end
                    end
                end
                default: begin
                    state     <= STATE_RUN;
                    field_sel <= FIELD_HOUR;
                end
            endcase
        end
    end

    // The ring is muted while setting the time. A key pressed while ringing
    // mutes it until the hh:mm match goes away.
    assign alarm_match = alarm_on && (run_hour == alarm_hour) &&
                         (run_minute == alarm_minute) && (state != STATE_SET);
    assign any_key     = key_mode || key_next || key_inc;
    assign silence_nxt = alarm_match && (silence || (alarm_ring && any_key));

    // Ring and silence registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            silence    <= 1'b0;
            alarm_ring <= 1'b0;
        end else begin
            silence    <= silence_nxt;
            alarm_ring <= alarm_match && !silence_nxt;
        end
    end

`ifdef CLOCK_KEEPER_HOURLY_CHIME_EN
    // Hourly chime: first five seconds of each hour, except while setting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chime <= 1'b0;
        end else begin
            chime <= (run_minute == 6'd0) && (run_second <= 6'd4) && (state != STATE_SET);
        end
    end
`else
    assign chime = 1'b0;
`endif

    // The hour carry-out has no consumer: the day simply wraps.
    logic unused_hour_carry;
    assign unused_hour_carry = hour_carry;

endmodule

// File: tb/tb_clock_keeper.sv
// tb_clock_keeper: directed scenarios plus randomized key/tick traffic,
// compared every cycle against a seconds-of-day reference model.
module tb_clock_keeper;

`ifdef CLOCK_KEEPER_HOURLY_CHIME_EN
    localparam bit CH_EN = 1'b1;
`else
    localparam bit CH_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_next = 1'b0;
    logic       key_inc = 1'b0;
    logic       alarm_on = 1'b0;
    logic [5:0] run_hour, run_minute, run_second;
    logic [5:0] edit_hour, edit_minute, edit_second;
    logic       set_en, alarm_en, alarm_ring, chime;
    logic [1:0] field_sel;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: running time as seconds of the day
    int m_t, m_st, m_fs, m_eh, m_em, m_es, m_ah, m_am;
    bit m_ring, m_sil, m_chime;

    clock_keeper dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .key_mode    (key_mode),
        .key_next    (key_next),
        .key_inc     (key_inc),
        .alarm_on    (alarm_on),
        .run_hour    (run_hour),
        .run_minute  (run_minute),
        .run_second  (run_second),
        .edit_hour   (edit_hour),
        .edit_minute (edit_minute),
        .edit_second (edit_second),
        .set_en      (set_en),
        .alarm_en    (alarm_en),
        .field_sel   (field_sel),
        .alarm_ring  (alarm_ring),
        .chime       (chime)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return {14'd0, 6'(h), 6'(m), 6'(s)};
    endfunction

    task automatic m_reset();
        m_t = 0; m_st = 0; m_fs = 0;
        m_eh = 0; m_em = 0; m_es = 0; m_ah = 0; m_am = 0;
        m_ring = 0; m_sil = 0; m_chime = 0;
    endtask

    // one clock edge of the reference behaviour (st: 0 RUN, 1 SET, 2 ALARM)
    task automatic m_step(input bit t, input bit m, input bit n, input bit i);
        int h, mi, s;
        bit match;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        match = alarm_on && (h == m_ah) && (mi == m_am) && (m_st != 1);
        if (!match) m_sil = 0;
        else if (m_ring && (m || n || i)) m_sil = 1;
        m_ring  = match && !m_sil;
        m_chime = CH_EN && (mi == 0) && (s <= 4) && (m_st != 1);
        case (m_st)
            0: begin
                if (t) m_t = (m_t + 1) % 86400;
                if (m) begin
                    m_st = 1; m_fs = 0; m_eh = h; m_em = mi; m_es = s;
                end
            end
            1: begin
                if (m) begin
                    m_t = m_eh * 3600 + m_em * 60 + m_es;
                    m_st = 2; m_fs = 0; m_eh = m_ah; m_em = m_am; m_es = 0;
                end else begin
                    if (i) begin
                        if (m_fs == 0) m_eh = (m_eh + 1) % 24;
                        else if (m_fs == 1) m_em = (m_em + 1) % 60;
                        else m_es = (m_es + 1) % 60;
                    end
                    if (n) m_fs = (m_fs + 1) % 3;
                end
            end
            default: begin
                if (t) m_t = (m_t + 1) % 86400;
                if (m) begin
                    m_st = 0; m_fs = 0;
                end else begin
                    if (i) begin
                        if (m_fs == 0) begin m_ah = (m_ah + 1) % 24; m_eh = m_ah; end
                        else begin m_am = (m_am + 1) % 60; m_em = m_am; end
                    end
                    if (n) m_fs = 1 - m_fs;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("run", hms(run_hour, run_minute, run_second), hms(m_t / 3600, (m_t / 60) % 60, m_t % 60));
        check_eq("edit", hms(edit_hour, edit_minute, edit_second), hms(m_eh, m_em, m_es));
        check_eq("ctrl", {28'd0, set_en, alarm_en, field_sel}, {28'd0, m_st == 1, m_st == 2, 2'(m_fs)});
        check_eq("ring", {31'd0, alarm_ring}, {31'd0, m_ring});
        check_eq("chime", {31'd0, chime}, {31'd0, m_chime});
    endtask

    // driver: one cycle of pulses, starting and ending at a falling edge
    task automatic cycle(input bit t, input bit m, input bit n, input bit i);
        tick_1hz = t; key_mode = m; key_next = n; key_inc = i;
        @(posedge clk);
        m_step(t, m, n, i);
        #1;
        tick_1hz = 0; key_mode = 0; key_next = 0; key_inc = 0;
        @(negedge clk);
        compare_all();
    endtask

    task automatic incs(input int k);
        for (int j = 0; j < k; j++) cycle(0, 0, 0, 1);
    endtask

    // from RUN: set the running time, finish back in RUN
    task automatic set_time(input int h, input int mi, input int s);
        int kh, km, ks;
        cycle(0, 1, 0, 0);
        kh = (h - m_eh + 24) % 24;
        km = (mi - m_em + 60) % 60;
        ks = (s - m_es + 60) % 60;
        incs(kh); cycle(0, 0, 1, 0);
        incs(km); cycle(0, 0, 1, 0);
        incs(ks);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
    endtask

    // from RUN: set the alarm time, finish back in RUN
    task automatic set_alarm(input int h, input int mi);
        int kh, km;
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        kh = (h - m_ah + 24) % 24;
        km = (mi - m_am + 60) % 60;
        incs(kh); cycle(0, 0, 1, 0);
        incs(km);
        cycle(0, 1, 0, 0);
    endtask

    initial begin
        bit t, m, n, i;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        compare_all();
        check_eq("reset_run", hms(run_hour, run_minute, run_second), 32'd0);

        // rollover through midnight, edit fields untouched by the carry
        cycle(0, 1, 0, 0);
        incs(23); cycle(0, 0, 1, 0);
        incs(59); cycle(0, 0, 1, 0);
        incs(58);
        cycle(0, 1, 0, 0);
        check_eq("commit_2359", hms(run_hour, run_minute, run_second), hms(23, 59, 58));
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check_eq("midnight", hms(run_hour, run_minute, run_second), 32'd0);
        check_eq("no_edit_carry", hms(edit_hour, edit_minute, edit_second), 32'd0);
        cycle(0, 1, 0, 0);

        // edit and commit: minute wraps without touching hour
        cycle(0, 1, 0, 0);
        incs(3); cycle(0, 0, 1, 0); incs(60);
        cycle(0, 1, 0, 0);
        check_eq("commit_0300", hms(run_hour, run_minute, run_second), hms(3, 0, 0));
        check_eq("set_to_alarm", {30'd0, set_en, alarm_en}, 32'd1);
        cycle(0, 1, 0, 0);

        // frozen time in SET; tick in the commit cycle is dropped
        cycle(0, 1, 0, 0);
        for (int j = 0; j < 10; j++) cycle(1, 0, 0, 0);
        check_eq("frozen", {26'd0, run_second}, 32'd0);
        cycle(0, 0, 1, 0); cycle(0, 0, 1, 0); incs(5);
        cycle(1, 1, 0, 0);
        check_eq("commit_tick", hms(run_hour, run_minute, run_second), hms(3, 0, 5));
        cycle(0, 1, 0, 0);

        // alarm and silence
        set_alarm(7, 30);
        alarm_on = 1;
        set_time(7, 29, 58);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check_eq("ring_lag", {31'd0, alarm_ring}, 32'd0);
        cycle(0, 0, 0, 0);
        check_eq("ring_on", {31'd0, alarm_ring}, 32'd1);
        cycle(0, 0, 0, 1);
        check_eq("silenced", {31'd0, alarm_ring}, 32'd0);
        for (int j = 0; j < 60; j++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check_eq("after_match", {31'd0, alarm_ring}, 32'd0);

        // mode + inc together in SET
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 1);
        check_eq("mode_wins_ctrl", {30'd0, set_en, alarm_en}, 32'd1);
        check_eq("mode_wins_edit", hms(edit_hour, edit_minute, edit_second), hms(7, 30, 0));
        cycle(0, 1, 0, 0);
        alarm_on = 0;

        // hourly chime
        set_time(9, 59, 58);
        for (int j = 0; j < 4; j++) cycle(1, 0, 0, 0);
        check_eq("chime_on", {31'd0, chime}, {31'd0, CH_EN});
        for (int j = 0; j < 4; j++) cycle(1, 0, 0, 0);
        check_eq("chime_off", {31'd0, chime}, 32'd0);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ((k % 300) == 0 && m_st == 0) begin
                set_alarm(m_t / 3600, (m_t / 60) % 60);
                alarm_on = 1;
            end
            if ($urandom_range(0, 199) == 0) alarm_on = ~alarm_on;
            t = ($urandom_range(0, 2) == 0);
            m = ($urandom_range(0, 39) == 0);
            n = ($urandom_range(0, 9) == 0);
            i = ($urandom_range(0, 4) == 0);
            if (m_st == 0 && m) t = 0;
            cycle(t, m, n, i);
        end

        // asynchronous reset in mid-edit
        for (int j = 0; j < 3 && m_st != 1; j++) cycle(0, 1, 0, 0);
        incs(2);
        #2 rst = 1;
        #1;
        m_reset();
        compare_all();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
